// File: rtl/semaforo_pkg.sv
// semaforo_pkg: state encoding, one-hot light codes and a state-to-lights decode shared by the traffic-light controller
package semaforo_pkg;
  typedef enum logic [1:0] {S_AG, S_AY, S_BG, S_BY} estado_t;
  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;
  function automatic logic [5:0] luzes(input estado_t s);
    return s == S_AG ? {LUZ_VERDE, LUZ_VERMELHO} :
           s == S_AY ? {LUZ_AMARELO, LUZ_VERMELHO} :
           s == S_BG ? {LUZ_VERMELHO, LUZ_VERDE} :
                       {LUZ_VERMELHO, LUZ_AMARELO};
  endfunction
endpackage

// File: rtl/semaforo.sv
// semaforo: two-way traffic-light Moore FSM with phase counter and latched crossing request; ports clk, rst (async high), bt (request), A/B (one-hot lights)
module semaforo
  import semaforo_pkg::*;
#(
  parameter logic [7:0] T_VERDE    = 8'd3,
  parameter logic [7:0] T_AMARELO  = 8'd1,
  parameter logic [7:0] T_VERMELHO = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  output logic [2:0] A,
  output logic [2:0] B
);
  estado_t state, nxt;
  logic [7:0] cnt;
  logic req, sai;
  always_comb begin
    sai = state == S_AG ? (cnt == T_VERDE - 8'd1 || req || bt) :
          state == S_BG ? (cnt == T_VERMELHO - T_AMARELO - 8'd1) :
                          (cnt == T_AMARELO - 8'd1);
    nxt = sai ? estado_t'(state + 2'd1) : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_AG;
      cnt    <= '0;
      req    <= 1'b0;
      {A, B} <= {LUZ_VERDE, LUZ_VERMELHO};
    end else begin
      state  <= nxt;
      cnt    <= sai ? 8'd0 : cnt + 8'd1;
      req    <= (state == S_AG && sai) ? 1'b0 : req | bt;
      {A, B} <= luzes(nxt);
    end
endmodule

// File: tb/tb_semaforo.sv
// tb_semaforo: directed self-checking bench for the semaforo traffic-light controller
module tb_semaforo;
  logic clk = 1'b0, rst = 1'b0, bt = 1'b0;
  logic [2:0] a, b, a2, b2;
  int checks = 0, fails = 0;
  semaforo dut (.clk(clk), .rst(rst), .bt(bt), .A(a), .B(b));
  semaforo #(.T_VERDE(8'd255), .T_AMARELO(8'd1), .T_VERMELHO(8'd255)) dut2 (.clk(clk), .rst(rst), .bt(bt), .A(a2), .B(b2));
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask
  task automatic tick;
    #1 clk = 1'b1;
    #4 clk = 1'b0;
    #5;
  endtask
  task automatic do_reset;
    bt = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
  endtask
  logic [5:0] seq [6] = '{6'b001100, 6'b001100, 6'b001100, 6'b010100, 6'b100001, 6'b100010};
  logic [5:0] lz [4] = '{6'b001100, 6'b010100, 6'b100001, 6'b100010};
  int len [4] = '{3, 1, 1, 1};
  initial begin
    logic [15:0] pat;
    int ms, mc, n;
    logic mreq, prev;
    // 1: reset state and free-running sequence
    rst = 1'b1;
    #3 check("rst_ab", {a, b}, 6'b001100);
    check("rst_ab2", {a2, b2}, 6'b001100);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("seq%0d", i), {a, b}, seq[i % 6]);
      tick();
    end
    // 2: press in first green cycle cuts green, request cleared
    do_reset();
    bt = 1'b1;
    tick();
    bt = 1'b0;
    check("bt_ag_yellow", a, 3'b010);
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("req_clear_g%0d", i), a, 3'b001);
      tick();
    end
    check("req_clear_y", a, 3'b010);
    // 3: press during B green shortens next A green to one cycle
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("bg_reach", {a, b}, 6'b100001);
    bt = 1'b1;
    tick();
    bt = 1'b0;
    check("bg_by", {a, b}, 6'b100010);
    tick();
    check("short_ag", a, 3'b001);
    tick();
    check("short_ay", a, 3'b010);
    // 4: asynchronous reset mid B green
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("async_pre", {a, b}, 6'b100001);
    #2 rst = 1'b1;
    #1 check("async_rst", {a, b}, 6'b001100);
    rst = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post_rst_g%0d", i), a, 3'b001);
      tick();
    end
    check("post_rst_y", a, 3'b010);
    // 5: irregular clock with button pulses against a phase model
    do_reset();
    ms = 0; mc = 0; mreq = 1'b0;
    pat = 16'b1111001010000111;
    for (int s = 0; s < 160; s++) begin
      bt = (s % 23 == 7) || (s % 37 == 20);
      #1 prev = clk;
      clk = pat[15 - (s % 16)];
      if (clk && !prev) begin
        if (ms == 0 && (mc == len[0] - 1 || mreq || bt)) begin
          ms = 1; mc = 0; mreq = 1'b0;
        end else if (ms != 0 && mc == len[ms] - 1) begin
          ms = (ms + 1) % 4; mc = 0; mreq = mreq | bt;
        end else begin
          mc++; mreq = mreq | bt;
        end
      end
      #4;
      check($sformatf("irr%0d", s), {a, b}, lz[ms]);
      check($sformatf("irr_oh_a%0d", s), 9'($onehot(a)), 9'd1);
      check($sformatf("irr_oh_b%0d", s), 9'($onehot(b)), 9'd1);
      check($sformatf("irr_red%0d", s), 9'(a == 3'b100 || b == 3'b100), 9'd1);
    end
    clk = 1'b0;
    bt = 1'b0;
    #5;
    // 6: long phases
    do_reset();
    n = 0;
    while (a2 == 3'b001 && n < 300) begin
      n++;
      tick();
    end
    check("long_ag", 9'(n), 9'd255);
    check("long_ay", a2, 3'b010);
    tick();
    n = 0;
    while (b2 == 3'b001 && n < 300) begin
      n++;
      tick();
    end
    check("long_bg", 9'(n), 9'd254);
    check("long_by", b2, 3'b010);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
